// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer. It uses the shared 32-bit ALU for one
// add (shift-add multiply) or one trial subtract (restoring divide) per cycle.
module alu_muldiv_seq #(
  parameter logic [3:0]  OP_ADD    = 4'h1,
  parameter logic [3:0]  OP_SUB    = 4'h2,
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        abort,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_carry
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, mcand;   // hi/lo double as rem/quot, mcand as divisor
  logic [1:0]  op_q;
  logic [31:0] hi_d, lo_d, sh, result;
  logic        take, req_div0;

  assign req_div0 = req_op[1] && (req_b == 32'd0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    alu_op     = 4'd0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    hi_d       = hi;
    lo_d       = lo;
    sh         = {hi[30:0], lo[31]};
    take       = 1'b0;

    case (state_q)
      IDLE: if (req_valid) state_d = req_div0 ? DONE : BUSY;
      BUSY: begin
        if (op_q[1]) begin
          alu_op = OP_SUB;
          alu_a  = sh;
          alu_b  = mcand;
          // A set rem[31] means the shifted value is 33 bits wide and always exceeds the divisor.
          take   = !alu_carry || hi[31];
          hi_d   = take ? alu_out : sh;
          lo_d   = {lo[30:0], take};
        end else begin
          alu_op = OP_ADD;
          alu_a  = hi;
          alu_b  = lo[0] ? mcand : 32'd0;
          hi_d   = {alu_carry, alu_out[31:1]};
          lo_d   = {alu_out[0], lo[31:1]};
        end
        if (cnt == 5'd31) state_d = DONE;
      end
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // MUL and DIVU return the low/quotient half, MULHU and REMU the high/remainder half.
  assign result = op_q[0] ? hi_d : lo_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt       <= 5'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      mcand     <= 32'd0;
      op_q      <= 2'd0;
      resp_data <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          cnt   <= 5'd0;
          hi    <= 32'd0;
          lo    <= req_op[1] ? req_a : req_b;
          mcand <= req_op[1] ? req_b : req_a;
          if (req_div0) resp_data <= req_op[0] ? req_a : DIV0_QUOT;
        end
        BUSY: begin
          hi  <= hi_d;
          lo  <= lo_d;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) resp_data <= result;
        end
        default: ;
      endcase
      // Any exit back to IDLE (handshake or abort) discards the result.
      if ((state_d == IDLE) && (state_q != IDLE)) resp_data <= 32'd0;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: a behavioural ALU, a transaction-level reference
// model compared every cycle, and directed vectors with literal expected results.
module tb_alu_muldiv_seq;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, abort, resp_valid, resp_ready, alu_carry;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b, resp_data, alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;

  int vectors     = 0;
  int miscompares = 0;
  int add_count   = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .abort(abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Shared ALU: add carry-out, subtract borrow.
  always_comb begin
    {alu_carry, alu_out} = 33'd0;
    case (alu_op)
      OP_ADD:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      default: {alu_carry, alu_out} = 33'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain arithmetic, timing as a cycle countdown.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_left  = 0;
  logic        m_div   = 1'b0;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_data  = '0;

  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (op)
      2'd0:    return prod[31:0];
      2'd1:    return prod[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= M_IDLE;
      m_data  <= '0;
    end else begin
      case (m_phase)
        M_IDLE: if (req_valid) begin
          m_div <= req_op[1];
          if (req_op[1] && req_b == 0) begin
            m_phase <= M_DONE;
            m_data  <= model_result(req_op, req_a, req_b);
          end else begin
            m_phase <= M_BUSY;
            m_left  <= 32;
            m_pend  <= model_result(req_op, req_a, req_b);
          end
        end
        M_BUSY: if (abort) m_phase <= M_IDLE;
                else begin
                  m_left <= m_left - 1;
                  if (m_left == 1) begin
                    m_phase <= M_DONE;
                    m_data  <= m_pend;
                  end
                end
        default: if (abort || resp_ready) m_phase <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(m_phase == M_IDLE));
    check("resp_valid", 32'(resp_valid), 32'(m_phase == M_DONE));
    if (m_phase == M_DONE) check("resp_data", resp_data, m_data);
    check("alu_op", 32'(alu_op),
          (m_phase == M_BUSY) ? 32'(m_div ? OP_SUB : OP_ADD) : 32'd0);
    if (m_phase != M_BUSY) begin
      check("alu_a_idle", alu_a, 32'd0);
      check("alu_b_idle", alu_b, 32'd0);
    end
    if (alu_op == OP_ADD) add_count++;
  end

  // Present a request for one cycle; returns at the first negedge after the accept edge.
  task automatic start(input logic [1:0] op, input logic [31:0] a, b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, b, exp,
                       input int exp_lat, input string name);
    int lat;
    start(op, a, b);
    wait_resp(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check(name, resp_data, exp);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    abort = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    add_count = 0;
    do_op(2'd0, 32'd7, 32'd6, 32'd42, 33, "mul_7x6");
    check("mul_add_cycles", 32'(add_count), 32'd32);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_max");
    do_op(2'd2, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    do_op(2'd3, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    do_op(2'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
    do_op(2'd2, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33, "divu_msb_3");
    do_op(2'd3, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, "remu_max_16");
    do_op(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_op(2'd3, 32'd5, 32'd0, 32'd5, 1, "remu_by0");

    // Back-pressure in DONE: result held, new requests refused.
    start(2'd1, 32'h0001_0000, 32'h0003_0000);
    wait_resp(lat);
    check("hold_latency", 32'(lat), 32'd33);
    req_op = 2'd2; req_a = 32'd9; req_b = 32'd0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, 32'd3);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_release_ready", 32'(req_ready), 32'd1);

    // abort in IDLE is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", 32'(req_ready), 32'd1);

    // abort at cnt=12: back to IDLE, no response ever appears.
    start(2'd0, 32'd7, 32'd6);
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end

    // rst at cnt=20: everything back to reset values, then a clean MUL.
    start(2'd0, 32'd5, 32'd5);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(2'd0, 32'd3, 32'd3, 32'd9, 33, "mul_3x3_after_rst");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
